control_sequencer: RTL and testbench

- Moore-style phase sequencer that drives the register-select/encode control lines (Gra, Grb, Grc, Rin, Rout, BAout, Cout) and the bus/memory strobes of the CPU datapath.
- Sits between the instruction register and the datapath. Reads opcode IR[31:27] and steps fetch and execute phases T0..T7.
- Stalls on a memory ready handshake.
- Supports load/store, immediate, register-register ALU, nop and halt instructions.

---
 rtl/control_sequencer_if.sv | 28 ++
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the phase sequencer and the CPU datapath: IR/memory-done in, control strobes out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_done;
  logic        Gra, Grb, Grc;
  logic        Rin, Rout, BAout;
  logic        Cout;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout;
  logic        Read, Write;
  logic        IRin, Yin, Zin, Zlowout;
  logic [4:0]  alu_op;
  logic        run;

  modport master (
    input  IR, mem_done,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
           PCout, PCin, IncPC, MARin, MDRin, MDRout,
           Read, Write, IRin, Yin, Zin, Zlowout, alu_op, run
  );

  modport slave (
    output IR, mem_done,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
           PCout, PCin, IncPC, MARin, MDRin, MDRout,
           Read, Write, IRin, Yin, Zin, Zlowout, alu_op, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore phase sequencer T0..T7 + HALT; controls decode combinationally from phase and IR[31:27].
// Stalls in T1 (fetch), T6 (ld) and T7 (st) until mem_done; reset forces T0 and blanks all strobes.
module control_sequencer #(
  parameter logic [4:0] OP_ADD = 5'b00011,
  parameter logic [4:0] OP_AND = 5'b00101,
  parameter logic [4:0] OP_OR  = 5'b00110
) (
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALU3, C_ALUI, C_NOP, C_HALT
  } iclass_t;

  state_t     state;
  logic [4:0] opcode;
  iclass_t    iclass;
  logic [4:0] alui_op;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  // Undefined opcodes fall through to nop.
  always_comb begin
    iclass = C_NOP;
    if (opcode == 5'b00000)
      iclass = C_LD;
    else if (opcode == 5'b00001)
      iclass = C_LDI;
    else if (opcode == 5'b00010)
      iclass = C_ST;
    else if (opcode >= 5'b00011 && opcode <= 5'b01011)
      iclass = C_ALU3;
    else if (opcode >= 5'b01100 && opcode <= 5'b01110)
      iclass = C_ALUI;
    else if (opcode == 5'b11011)
      iclass = C_HALT;
  end

  always_comb begin
    alui_op = OP_OR;
    if (opcode == 5'b01100)
      alui_op = OP_ADD;
    else if (opcode == 5'b01101)
      alui_op = OP_AND;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_T0;
    end else begin
      case (state)
        S_T0: state <= S_T1;
        S_T1: if (bus.mem_done) state <= S_T2;
        S_T2: state <= (iclass == C_HALT) ? S_HALT : S_T3;
        S_T3: state <= (iclass == C_NOP) ? S_T0 : S_T4;
        S_T4: state <= S_T5;
        S_T5: state <= (iclass == C_LD || iclass == C_ST) ? S_T6 : S_T0;
        S_T6: begin
          if (iclass != C_LD || bus.mem_done)
            state <= S_T7;
        end
        S_T7: begin
          if (iclass != C_ST || bus.mem_done)
            state <= S_T0;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_T0;
      endcase
    end
  end

  always_comb begin
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.PCout   = 1'b0;
    bus.PCin    = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.alu_op  = 5'd0;
    bus.run     = reset || (state != S_HALT);

    // Reset blanks the strobes immediately, without waiting for a clock edge.
    if (!reset) begin
      case (state)
        S_T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
        end
        S_T1: begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
        end
        S_T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        S_T3: begin
          if (iclass == C_ALU3 || iclass == C_ALUI) begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end else if (iclass == C_LD || iclass == C_LDI || iclass == C_ST) begin
            bus.Grb   = 1'b1;
            bus.BAout = 1'b1;
            bus.Yin   = 1'b1;
          end
        end
        S_T4: begin
          if (iclass == C_ALU3) begin
            bus.Grc    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opcode;
          end else if (iclass == C_ALUI) begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = alui_op;
          end else if (iclass == C_LD || iclass == C_LDI || iclass == C_ST) begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = OP_ADD;
          end
        end
        S_T5: begin
          if (iclass == C_LD || iclass == C_ST) begin
            bus.Zlowout = 1'b1;
            bus.MARin   = 1'b1;
          end else if (iclass == C_ALU3 || iclass == C_ALUI || iclass == C_LDI) begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
        end
        S_T6: begin
          if (iclass == C_LD) begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
          end else if (iclass == C_ST) begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.MDRin = 1'b1;
          end
        end
        S_T7: begin
          if (iclass == C_LD) begin
            bus.MDRout = 1'b1;
            bus.Gra    = 1'b1;
            bus.Rin    = 1'b1;
          end else if (iclass == C_ST) begin
            bus.Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed + randomized check of control_sequencer against a per-instruction expected-trace model.
module tb_control_sequencer;

  logic clock;
  logic reset;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef logic [24:0] vec_t;   // {run, alu_op[4:0], strobes[18:0]}

  localparam logic [18:0] GRA   = 19'd1 << 0;
  localparam logic [18:0] GRB   = 19'd1 << 1;
  localparam logic [18:0] GRC   = 19'd1 << 2;
  localparam logic [18:0] RIN   = 19'd1 << 3;
  localparam logic [18:0] ROUT  = 19'd1 << 4;
  localparam logic [18:0] BAOUT = 19'd1 << 5;
  localparam logic [18:0] COUT  = 19'd1 << 6;
  localparam logic [18:0] PCOUT = 19'd1 << 7;
  localparam logic [18:0] PCIN  = 19'd1 << 8;
  localparam logic [18:0] INCPC = 19'd1 << 9;
  localparam logic [18:0] MARIN = 19'd1 << 10;
  localparam logic [18:0] MDRIN = 19'd1 << 11;
  localparam logic [18:0] MDROUT= 19'd1 << 12;
  localparam logic [18:0] READ  = 19'd1 << 13;
  localparam logic [18:0] WRITE = 19'd1 << 14;
  localparam logic [18:0] IRIN  = 19'd1 << 15;
  localparam logic [18:0] YIN   = 19'd1 << 16;
  localparam logic [18:0] ZIN   = 19'd1 << 17;
  localparam logic [18:0] ZLOW  = 19'd1 << 18;

  int   n_assert = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  logic md_q[$];

  function automatic vec_t sample();
    return {bus.run, bus.alu_op,
            bus.Zlowout, bus.Zin, bus.Yin, bus.IRin, bus.Write, bus.Read,
            bus.MDRout, bus.MDRin, bus.MARin, bus.IncPC, bus.PCin, bus.PCout,
            bus.Cout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra};
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Non-wait cycle: mem_done is random and must be ignored.
  task automatic push(input logic [18:0] s, input logic [4:0] a, input logic r);
    exp_q.push_back({r, a, s});
    md_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // Wait phase: held for w extra cycles, mem_done high on the last one.
  task automatic push_wait(input logic [18:0] s, input int w);
    for (int k = 0; k < w; k++) begin
      exp_q.push_back({1'b1, 5'd0, s});
      md_q.push_back(1'b0);
    end
    exp_q.push_back({1'b1, 5'd0, s});
    md_q.push_back(1'b1);
  endtask

  // Expected per-cycle trace of one instruction, straight from the phase tables.
  task automatic gen(input logic [4:0] op, input int w1, input int w2);
    push(PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'b1);
    push_wait(ZLOW | PCIN | READ | MDRIN, w1);
    push(MDROUT | IRIN, 5'd0, 1'b1);
    if (op == 5'd27) begin
      for (int k = 0; k < 20; k++) push(19'd0, 5'd0, 1'b0);
    end else if (op >= 5'd3 && op <= 5'd11) begin
      push(GRB | ROUT | YIN, 5'd0, 1'b1);
      push(GRC | ROUT | ZIN, op, 1'b1);
      push(ZLOW | GRA | RIN, 5'd0, 1'b1);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(GRB | ROUT | YIN, 5'd0, 1'b1);
      push(COUT | ZIN, (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b00101 : 5'b00110, 1'b1);
      push(ZLOW | GRA | RIN, 5'd0, 1'b1);
    end else if (op <= 5'd2) begin
      push(GRB | BAOUT | YIN, 5'd0, 1'b1);
      push(COUT | ZIN, 5'b00011, 1'b1);
      if (op == 5'd1) begin
        push(ZLOW | GRA | RIN, 5'd0, 1'b1);
      end else if (op == 5'd0) begin
        push(ZLOW | MARIN, 5'd0, 1'b1);
        push_wait(READ | MDRIN, w2);
        push(MDROUT | GRA | RIN, 5'd0, 1'b1);
      end else begin
        push(ZLOW | MARIN, 5'd0, 1'b1);
        push(GRA | ROUT | MDRIN, 5'd0, 1'b1);
        push_wait(WRITE, w2);
      end
    end else begin
      push(19'd0, 5'd0, 1'b1);
    end
  endtask

  // Runs n queued cycles; entered and left just after a falling edge.
  task automatic run_n(input string tag, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      bus.mem_done = md_q.pop_front();
      #1;
      v = sample();
      check(tag, v, exp_q.pop_front());
      n_assert++;
      assert (!(bus.Rin && bus.Rout) && !(bus.Read && bus.Write)) else begin
        n_fail++;
        $error("FAIL %s_excl: observed Rin/Rout/Read/Write=%b%b%b%b expected no pair both high",
               tag, bus.Rin, bus.Rout, bus.Read, bus.Write);
      end
      @(negedge clock);
    end
  endtask

  task automatic instr(input string tag, input logic [31:0] ir, input int w1, input int w2);
    bus.IR = ir;
    gen(ir[31:27], w1, w2);
    run_n(tag, exp_q.size());
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset = 1'b1;
    #1 check({tag, "_async"}, sample(), {1'b1, 5'd0, 19'd0});
    @(posedge clock);
    #1 check({tag, "_held"}, sample(), {1'b1, 5'd0, 19'd0});
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    md_q.delete();
  endtask

  logic [31:0] rnd;
  logic [4:0]  op;

  initial begin
    reset        = 1'b1;
    bus.IR       = 32'h0;
    bus.mem_done = 1'b1;
    @(negedge clock);
    check("reset_state", sample(), {1'b1, 5'd0, 19'd0});
    @(posedge clock);
    #1 check("reset_edge", sample(), {1'b1, 5'd0, 19'd0});
    @(negedge clock);
    reset = 1'b0;

    instr("add",   32'h18000000, 0, 0);
    instr("ld_w3", 32'h00800005, 3, 0);
    instr("st_w2", 32'h10800010, 0, 2);
    instr("andi",  32'h68800003, 0, 0);
    instr("undef", 32'hF8000000, 0, 0);
    instr("ldi",   32'h08000001, 1, 0);
    instr("ori",   32'h70000000, 0, 0);
    instr("addi",  32'h60000000, 0, 0);
    instr("nop",   32'hD0000000, 2, 0);

    for (int n = 0; n < 60; n++) begin
      rnd = $urandom();
      op  = rnd[31:27];
      if (op == 5'd27) op = 5'd26;
      instr("rand", {op, rnd[26:0]}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    instr("halt", 32'hD8000000, 1, 0);
    reset_pulse("halt_reset");
    instr("after_halt", 32'h28000000, 0, 0);

    // Reset dropped mid-T6 of a load that is still waiting on memory.
    bus.IR = 32'h00800005;
    gen(5'd0, 1, 3);
    run_n("ld_pre", 7);
    bus.mem_done = 1'b0;
    #1 check("ld_t6", sample(), exp_q.pop_front());
    reset_pulse("mid_t6");
    instr("restart", 32'h18000000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
